// File: rtl/quad_follower.sv
// quad_follower: closed-loop step/dir sequencer.
// Tracks a target position (usually the quad encoder count) by emitting
// step/dir pulses with guaranteed direction-setup, step-high and step-low
// timing for the stepper driver.
//
// Build option: define QF_RAMP_EN to stretch the low phase of the first
// steps of a move (start-up ramp). Without it the low phase is fixed.

module quad_follower #(
  parameter int POS_BITS         = 8,
  parameter int DIR_SETUP_CYCLES = 2,
  parameter int STEP_HIGH_CYCLES = 2,
  parameter int STEP_LOW_CYCLES  = 3,
  parameter int RAMP_START       = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic [POS_BITS-1:0] target,
  output logic                step,
  output logic                dir,
  output logic [POS_BITS-1:0] position,
  output logic                busy,
  output logic                at_target
);

  // The phase counter is sized for the longest possible phase, including the
  // ramped low phase, so one datapath width serves both build variants.
  localparam int LOW_MAX   = STEP_LOW_CYCLES + RAMP_START;
  localparam int MAX_A     = (DIR_SETUP_CYCLES > STEP_HIGH_CYCLES) ? DIR_SETUP_CYCLES
                                                                   : STEP_HIGH_CYCLES;
  localparam int MAX_PHASE = (MAX_A > LOW_MAX) ? MAX_A : LOW_MAX;
  localparam int CNT_W     = (MAX_PHASE > 1) ? $clog2(MAX_PHASE) : 1;

  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(DIR_SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] HIGH_LAST  = CNT_W'(STEP_HIGH_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOW_BASE   = CNT_W'(STEP_LOW_CYCLES - 1);

`ifdef QF_RAMP_EN
  localparam int EXTRA_W = (RAMP_START > 1) ? $clog2(RAMP_START + 1) : 1;
  localparam logic [EXTRA_W-1:0] EXTRA_LOAD = EXTRA_W'(RAMP_START);
`endif

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    DIR_SETUP = 2'd1,
    STEP_HIGH = 2'd2,
    STEP_LOW  = 2'd3
  } state_t;

  // Direction wanted for a non-zero difference: MSB clear means "go up".
  // The half-range difference (MSB set, rest zero) resolves downwards.
  function automatic logic want_up(input logic [POS_BITS-1:0] d);
    want_up = ~d[POS_BITS-1];
  endfunction

  // Position after one step in the given direction, wrapping modulo 2^POS_BITS.
  function automatic logic [POS_BITS-1:0] next_pos(input logic [POS_BITS-1:0] p,
                                                   input logic                up);
    if (up) begin
      next_pos = p + POS_BITS'(1);
    end else begin
      next_pos = p - POS_BITS'(1);
    end
  endfunction

  state_t              state_r;
  state_t              state_s;
  logic [CNT_W-1:0]    cnt_r;
  logic [CNT_W-1:0]    cnt_s;
  logic                step_s;
  logic                dir_s;
  logic [POS_BITS-1:0] pos_s;
  logic [POS_BITS-1:0] diff_s;
  logic                request_s;
  logic [CNT_W-1:0]    low_last_s;

`ifdef QF_RAMP_EN
  logic [EXTRA_W-1:0]  extra_r;
  logic [EXTRA_W-1:0]  extra_s;
`endif

  assign diff_s    = target - position;
  assign request_s = enable && (diff_s != {POS_BITS{1'b0}});

  assign busy      = (state_r != IDLE);
  assign at_target = (state_r == IDLE) && (position == target);

  // Last count value of the low phase, stretched by the ramp when enabled.
`ifdef QF_RAMP_EN
  assign low_last_s = LOW_BASE + CNT_W'(extra_r);
`else
  assign low_last_s = LOW_BASE;
`endif

  // Next-state, phase counter and output update decisions.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    step_s  = step;
    dir_s   = dir;
    pos_s   = position;
`ifdef QF_RAMP_EN
    extra_s = extra_r;
`endif
    case (state_r)
      IDLE: begin
        if (request_s) begin
          if (want_up(diff_s) == dir) begin
            // Direction already right: pulse starts on the next edge.
            state_s = STEP_HIGH;
            cnt_s   = {CNT_W{1'b0}};
            step_s  = 1'b1;
            pos_s   = next_pos(position, dir);
          end else begin
            // Change direction first and let it settle before stepping.
            state_s = DIR_SETUP;
            cnt_s   = {CNT_W{1'b0}};
            dir_s   = want_up(diff_s);
`ifdef QF_RAMP_EN
            extra_s = EXTRA_LOAD;
`endif
          end
        end else begin
          // Stopped: a later start begins with the full ramp.
`ifdef QF_RAMP_EN
          extra_s = EXTRA_LOAD;
`endif
          cnt_s = {CNT_W{1'b0}};
        end
      end
      DIR_SETUP: begin
        if (cnt_r == SETUP_LAST) begin
          state_s = STEP_HIGH;
          cnt_s   = {CNT_W{1'b0}};
          step_s  = 1'b1;
          pos_s   = next_pos(position, dir);
        end else begin
          cnt_s = cnt_r + CNT_W'(1);
        end
      end
      STEP_HIGH: begin
        if (cnt_r == HIGH_LAST) begin
          state_s = STEP_LOW;
          cnt_s   = {CNT_W{1'b0}};
          step_s  = 1'b0;
        end else begin
          cnt_s = cnt_r + CNT_W'(1);
        end
      end
      STEP_LOW: begin
        if (cnt_r == low_last_s) begin
          state_s = IDLE;
          cnt_s   = {CNT_W{1'b0}};
`ifdef QF_RAMP_EN
          // Each completed step shortens the next low phase, down to the base.
          if (extra_r != {EXTRA_W{1'b0}}) begin
            extra_s = extra_r - EXTRA_W'(1);
          end else begin
            extra_s = extra_r;
          end
`endif
        end else begin
          cnt_s = cnt_r + CNT_W'(1);
        end
      end
      default: begin
        state_s = IDLE;
        cnt_s   = {CNT_W{1'b0}};
        step_s  = 1'b0;
      end
    endcase
  end

  // State, counter and registered driver outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r  <= IDLE;
      cnt_r    <= {CNT_W{1'b0}};
      step     <= 1'b0;
      dir      <= 1'b0;
      position <= {POS_BITS{1'b0}};
    end else begin
      state_r  <= state_s;
      cnt_r    <= cnt_s;
      step     <= step_s;
      dir      <= dir_s;
      position <= pos_s;
    end
  end

`ifdef QF_RAMP_EN
  // Ramp register: extra low cycles applied to the current step.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      extra_r <= EXTRA_LOAD;
    end else begin
      extra_r <= extra_s;
    end
  end
`endif

endmodule

// File: tb/tb_quad_follower.sv
// Directed bench for quad_follower (default parameters).
// With QF_RAMP_EN defined the low-phase expectations switch to the ramp
// profile and the cycle-exact pulse trace is not applied.

module tb_quad_follower;

  logic       clk;
  logic       reset;
  logic       enable;
  logic [7:0] target;
  logic       step;
  logic       dir;
  logic [7:0] position;
  logic       busy;
  logic       at_target;

  int errors = 0;
  int checks = 0;

  // Monitor state updated by tick()
  int  rises;
  int  dir_changes;
  int  cur_low;
  int  lows[$];
  logic prev_step;
  logic prev_dir;

  quad_follower dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .target    (target),
    .step      (step),
    .dir       (dir),
    .position  (position),
    .busy      (busy),
    .at_target (at_target)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    rises       = 0;
    dir_changes = 0;
    cur_low     = 0;
    lows.delete();
    prev_step   = step;
    prev_dir    = dir;
  endtask

  // One clock; samples 1 time unit after the rising edge and updates monitors.
  task automatic tick();
    @(posedge clk);
    #1;
    if (step && !prev_step) rises++;
    if (dir !== prev_dir) dir_changes++;
    if (!step && busy) begin
      cur_low++;
    end else if (cur_low > 0) begin
      lows.push_back(cur_low);
      cur_low = 0;
    end
    prev_step = step;
    prev_dir  = dir;
  endtask

  // Clock until idle at target, bounded by maxc cycles.
  task automatic run_move(input int maxc, output bit timeout);
    timeout = 1'b1;
    for (int i = 0; i < maxc; i++) begin
      tick();
      if (!busy && at_target) begin
        timeout = 1'b0;
        break;
      end
    end
  endtask

  initial begin
    bit        to;
    logic [19:0] trace;
    int        exp_low[6];

    // ---- reset state ----
    reset  = 1'b1;
    enable = 1'b1;
    target = 8'h00;
    #1;
    chk("rst_step", step, 1'b0);
    chk("rst_dir", dir, 1'b0);
    chk("rst_pos", position, 8'h00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_at_target", at_target, 1'b1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;

    // ---- move 0 -> 3 with direction change ----
    target = 8'h03;
    clear_mon();
    trace = 20'h0;
    for (int i = 0; i < 20; i++) begin
      tick();
      trace[i] = step;
      if (i == 0) begin
        chk("up_dir_first", dir, 1'b1);
        chk("up_busy_first", busy, 1'b1);
      end
    end
`ifndef QF_RAMP_EN
    chk("up_step_trace", trace, 20'h0C30C);
`endif
    if (busy) begin
      run_move(100, to);
      chk("up_timeout", to, 1'b0);
    end
    chk("up_pos", position, 8'h03);
    chk("up_busy_end", busy, 1'b0);
    chk("up_at_target", at_target, 1'b1);
    chk("up_rises", rises, 3);

    // ---- reset asserted mid STEP_HIGH ----
    target = 8'h05;
    tick();
    chk("pre_rst_step", step, 1'b1);
    chk("pre_rst_pos", position, 8'h04);
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_step", step, 1'b0);
    chk("async_rst_pos", position, 8'h00);
    chk("async_rst_busy", busy, 1'b0);
    target = 8'h00;
    #1;
    reset = 1'b0;

    // ---- down through zero, direction already correct ----
    target = 8'hFE;
    clear_mon();
    tick();
    chk("dn_first_step", step, 1'b1);
    chk("dn_first_pos", position, 8'hFF);
    run_move(100, to);
    chk("dn_timeout", to, 1'b0);
    chk("dn_pos", position, 8'hFE);
    chk("dn_rises", rises, 2);
    chk("dn_dir_changes", dir_changes, 0);
    chk("dn_dir", dir, 1'b0);

    // ---- go up to 2 (wrapping FF->00), then retarget mid-pulse ----
    target = 8'h02;
    run_move(200, to);
    chk("wrap_up_timeout", to, 1'b0);
    chk("wrap_up_pos", position, 8'h02);
    chk("wrap_up_dir", dir, 1'b1);
    target = 8'h05;
    clear_mon();
    tick();
    chk("retgt_step", step, 1'b1);
    chk("retgt_pos", position, 8'h03);
    target = 8'h00;
    run_move(200, to);
    chk("retgt_timeout", to, 1'b0);
    chk("retgt_pos_end", position, 8'h00);
    chk("retgt_dir_end", dir, 1'b0);
    chk("retgt_rises", rises, 4);
    chk("retgt_dir_changes", dir_changes, 1);

    // ---- half-range target goes down; enable drops mid-pulse ----
    target = 8'h80;
    clear_mon();
    tick();
    chk("half_step", step, 1'b1);
    chk("half_pos", position, 8'hFF);
    enable = 1'b0;
    for (int i = 0; i < 14; i++) tick();
    chk("en_off_rises", rises, 1);
    chk("en_off_pos", position, 8'hFF);
    chk("en_off_step", step, 1'b0);
    chk("en_off_busy", busy, 1'b0);
    chk("en_off_dir", dir, 1'b0);

    // ---- six-step move from a stop, low-phase lengths ----
`ifdef QF_RAMP_EN
    exp_low = '{7, 6, 5, 4, 3, 3};
`else
    exp_low = '{3, 3, 3, 3, 3, 3};
`endif
    target = 8'hF9;
    enable = 1'b1;
    clear_mon();
    run_move(200, to);
    chk("six_timeout", to, 1'b0);
    chk("six_pos", position, 8'hF9);
    chk("six_rises", rises, 6);
    chk("six_low_count", lows.size(), 6);
    for (int i = 0; i < 6; i++) begin
      if (i < lows.size()) begin
        chk($sformatf("six_low_%0d", i), lows[i], exp_low[i]);
      end else begin
        chk($sformatf("six_low_%0d", i), 0, exp_low[i]);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
